capture_watermark_pipe: RTL
===========================

// Module: capture_watermark_pipe
// PURPOSE
// - Parametrised camera-capture + watermark engine on the pixel clock.
// - Assembles BPP camera bytes per pixel and tracks frame/line sync.
// - Embeds WM_BITS watermark bits into each pixel's LSBs; mode and key are selectable per frame.
// - Emits watermarked pixels with a frame-linear address for the frame-buffer writer.
// PARAMETERS
// - DW        8       camera data bus width
// - BPP       2       bytes per pixel (first byte = MS byte)
// - ADDR_W    19      pixel address width
// - FRAME_PIX 307200  max pixels per frame (640x480); legal range 1..2**ADDR_W
// - WM_BITS   1       LSBs replaced or XORed per pixel; legal range 1..8
// PORTS
// - pclk              in   1         pixel clock; all logic on rising edge
// - rst               in   1         synchronous, active-high reset
// - vsync             in   1         frame sync; high = vertical blanking
// - href              in   1         line valid; bytes sampled while high
// - d                 in   DW        camera byte
// - mode_in           in   2         0 bypass, 1 LFSR replace, 2 LFSR XOR, 3 static key replace
// - key_in            in   16        watermark key / LFSR seed
// - wked_pixel        out  DW*BPP    watermarked pixel
// - wked_pixel_ready  out  1         one-cycle strobe: wked_pixel and wked_pixel_adrr valid
// - wked_pixel_adrr   out  ADDR_W    pixel address in frame, 0-based
// - frame_cnt         out  8         completed frames, wraps 255->0
// - frame_overrun     out  1         sticky: frame carried more than FRAME_PIX pixels
// BEHAVIOUR
// - Reset (rst=1 at a pclk edge):
//   - All outputs 0; FSM = S_SYNC; LFSR = 16'hACE1; byte counter, address and shadow regs cleared.
//   - Reset mid-frame discards all in-flight pixels; pipeline bubbles are flushed.
// - FSM:
//   - S_SYNC: ignore data. vsync=1 -> S_VBLANK.
//   - S_VBLANK: ignore data. vsync falling edge (prev=1, now=0) -> S_ACTIVE. Same cycle:
//     - latch mode_in and key_in into shadow regs;
//     - LFSR <= key_in, or 16'hACE1 if key_in==0;
//     - address <= 0; frame_overrun <= 0.
//   - S_ACTIVE: capture while href=1. vsync=1 -> S_VBLANK and frame_cnt <= frame_cnt+1.
// - Byte assembly:
//   - Byte counter runs 0..BPP-1 and shifts d in MSB-first.
//   - Counter clears whenever href=0 or vsync=1; partial pixels are discarded.
//   - A pixel completes on the cycle the byte with counter==BPP-1 is sampled.
// - Pipeline, where cycle k = cycle that samples the last byte:
//   - Cycle k+1: stage-1 register holds the raw pixel and its address.
//   - Cycle k+2: wked_pixel, wked_pixel_adrr and wked_pixel_ready=1 are registered out.
//   - Fixed latency 2; ready is high for exactly 1 cycle per pixel.
//   - Back-to-back pixels every BPP cycles are sustained; no stalls.
// - Watermark (w = WM_BITS), upper bits always pass through unchanged:
//   - mode 0: pixel unchanged.
//   - mode 1: LSBs[w-1:0] = lfsr[w-1:0].
//   - mode 2: LSBs[w-1:0] ^= lfsr[w-1:0].
//   - mode 3: LSBs[w-1:0] = key_shadow[w-1:0].
// - LFSR:
//   - 16-bit Fibonacci, taps 16,14,13,11.
//   - lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
//   - Steps once per accepted pixel, after its bits are used. Steps in every mode.
// - Address:
//   - Increments per accepted pixel.
//   - Once FRAME_PIX pixels are accepted, further pixels are dropped (no ready).
//   - On a drop, frame_overrun <= 1; it holds until the next frame start.
// - Simultaneous events:
//   - vsync rising in the cycle a pixel completes: that pixel is dropped and frame_cnt still increments.
//   - A rst edge overrides every other event.
// - mode_in / key_in changes mid-frame take effect only at the next vsync falling edge.
// - frame_cnt increments only on S_ACTIVE->S_VBLANK; the partial first frame after reset is not counted.
// TESTING
// - Reset, then href/data with vsync never high -> wked_pixel_ready stays 0 and all outputs stay 0.
// - mode 0; frame start; bytes 0xAB,0xCD -> wked_pixel=16'hABCD, adrr=0, ready exactly 2 cycles after 0xCD sampled.
// - mode 1, key 16'h0001, WM_BITS=1; pixels 16'h0000, 16'hFFFF:
//   - -> first pixel 16'h0001 (lfsr bit0=1);
//   - -> second pixel 16'hFFFE (lfsr now 16'h0002).
// - FRAME_PIX=4; 5 pixels in one frame -> adrr 0..3 with ready; 5th dropped; frame_overrun=1; cleared at next vsync fall.
// - href drops after 1 byte (0x11), next line sends 0x22,0x33 -> single pixel 16'h2233 at the next address.
// - mode_in 0->2 mid-frame -> current frame stays unmodified, next frame XORed; frame_cnt increments 1 per vsync rise, 255->0.

Source files
------------

// File: rtl/capture_watermark_pipe_if.sv
// Camera-side and frame-buffer-side signal bundle for capture_watermark_pipe.
// master drives the camera/config inputs; slave is the capture engine.
interface capture_watermark_pipe_if #(
  parameter int DW     = 8,
  parameter int BPP    = 2,
  parameter int ADDR_W = 19
);
  logic                vsync;
  logic                href;
  logic [DW-1:0]       d;
  logic [1:0]          mode_in;
  logic [15:0]         key_in;
  logic [DW*BPP-1:0]   wked_pixel;
  logic                wked_pixel_ready;
  logic [ADDR_W-1:0]   wked_pixel_adrr;
  logic [7:0]          frame_cnt;
  logic                frame_overrun;

  modport master (
    output vsync, href, d, mode_in, key_in,
    input  wked_pixel, wked_pixel_ready, wked_pixel_adrr, frame_cnt, frame_overrun
  );

  modport slave (
    input  vsync, href, d, mode_in, key_in,
    output wked_pixel, wked_pixel_ready, wked_pixel_adrr, frame_cnt, frame_overrun
  );
endinterface

// File: rtl/capture_watermark_pipe.sv
// Camera capture engine: assembles BPP-byte pixels, embeds LSB watermark bits
// and emits each pixel with its frame-linear address two cycles later.
module capture_watermark_pipe #(
  parameter int DW        = 8,
  parameter int BPP       = 2,
  parameter int ADDR_W    = 19,
  parameter int FRAME_PIX = 307200,
  parameter int WM_BITS   = 1
) (
  input  logic                      pclk,
  input  logic                      rst,
  capture_watermark_pipe_if.slave   cam
);

  localparam int PW  = DW * BPP;
  localparam int CW  = (BPP > 1) ? $clog2(BPP) : 1;
  localparam int AW1 = ADDR_W + 1;
  localparam logic [15:0]    LFSR_INIT = 16'hACE1;
  localparam logic [AW1-1:0] PIX_MAX   = AW1'(FRAME_PIX);
  localparam logic [CW-1:0]  BCNT_LAST = CW'(BPP - 1);

  typedef enum logic [1:0] {S_SYNC = 2'd0, S_VBLANK = 2'd1, S_ACTIVE = 2'd2} state_e;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic [PW-1:0] apply_wm(input logic [PW-1:0] pix, input logic [1:0] mode,
                                             input logic [7:0] bits);
    logic [PW-1:0] mask;
    logic [PW-1:0] ext;
    mask = {PW{1'b0}};
    for (int i = 0; i < WM_BITS; i++) mask[i] = 1'b1;
    ext = PW'(bits) & mask;
    case (mode)
      2'd1:    return (pix & ~mask) | ext;
      2'd2:    return pix ^ ext;
      2'd3:    return (pix & ~mask) | ext;
      default: return pix;
    endcase
  endfunction

  state_e            state_q, state_d;
  logic              vsync_prev_q;
  logic [CW-1:0]     bcnt_q;
  logic [PW-1:0]     shift_q;
  logic [AW1-1:0]    pcnt_q;
  logic [15:0]       lfsr_q;
  logic [15:0]       key_sh_q;
  logic [1:0]        mode_sh_q;
  logic [7:0]        frame_cnt_q;
  logic              overrun_q;
  logic              s1_valid_q;
  logic [PW-1:0]     s1_pix_q;
  logic [ADDR_W-1:0] s1_addr_q;
  logic [1:0]        s1_mode_q;
  logic [7:0]        s1_bits_q;
  logic              ready_q;
  logic [PW-1:0]     pixel_q;
  logic [ADDR_W-1:0] addr_q;

  logic              frame_start_s, frame_end_s, capture_s, pix_done_s, accept_s, drop_s;
  logic [PW+DW-1:0]  cat_s;
  logic [PW-1:0]     pix_s;

  assign cat_s = {shift_q, cam.d};
  assign pix_s = cat_s[PW-1:0];

  // FSM state register
  always_ff @(posedge pclk) begin
    if (rst) state_q <= S_SYNC;
    else     state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_SYNC:   if (cam.vsync) state_d = S_VBLANK; else state_d = S_SYNC;
      S_VBLANK: if (vsync_prev_q && !cam.vsync) state_d = S_ACTIVE; else state_d = S_VBLANK;
      S_ACTIVE: if (cam.vsync) state_d = S_VBLANK; else state_d = S_ACTIVE;
      default:  state_d = S_SYNC;
    endcase
  end

  // FSM-derived strobes; a pixel completing while vsync is high is never captured
  always_comb begin
    frame_start_s = 1'b0;
    frame_end_s   = 1'b0;
    capture_s     = 1'b0;
    case (state_q)
      S_VBLANK: frame_start_s = vsync_prev_q & ~cam.vsync;
      S_ACTIVE: begin
        frame_end_s = cam.vsync;
        capture_s   = cam.href & ~cam.vsync;
      end
      default: begin
        frame_start_s = 1'b0;
        capture_s     = 1'b0;
      end
    endcase
    if (capture_s && (bcnt_q == BCNT_LAST)) pix_done_s = 1'b1;
    else                                    pix_done_s = 1'b0;
    accept_s = pix_done_s & (pcnt_q < PIX_MAX);
    drop_s   = pix_done_s & ~accept_s;
  end

  // Byte assembly, per-frame shadow config, LFSR, address and frame bookkeeping
  always_ff @(posedge pclk) begin
    if (rst) begin
      vsync_prev_q <= 1'b0;
      bcnt_q       <= {CW{1'b0}};
      shift_q      <= {PW{1'b0}};
      pcnt_q       <= {AW1{1'b0}};
      lfsr_q       <= LFSR_INIT;
      key_sh_q     <= 16'h0000;
      mode_sh_q    <= 2'd0;
      frame_cnt_q  <= 8'd0;
      overrun_q    <= 1'b0;
    end else begin
      vsync_prev_q <= cam.vsync;
      if (capture_s) begin
        shift_q <= pix_s;
        bcnt_q  <= pix_done_s ? {CW{1'b0}} : bcnt_q + CW'(1);
      end else begin
        bcnt_q  <= {CW{1'b0}};
      end
      if (frame_start_s) begin
        mode_sh_q <= cam.mode_in;
        key_sh_q  <= cam.key_in;
        lfsr_q    <= (cam.key_in == 16'h0000) ? LFSR_INIT : cam.key_in;
        pcnt_q    <= {AW1{1'b0}};
        overrun_q <= 1'b0;
      end else if (accept_s) begin
        lfsr_q    <= lfsr_step(lfsr_q);
        pcnt_q    <= pcnt_q + AW1'(1);
      end else if (drop_s) begin
        overrun_q <= 1'b1;
      end
      if (frame_end_s) frame_cnt_q <= frame_cnt_q + 8'd1;
    end
  end

  // Two-stage output pipeline: raw pixel plus the watermark bits in use at acceptance
  always_ff @(posedge pclk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_pix_q   <= {PW{1'b0}};
      s1_addr_q  <= {ADDR_W{1'b0}};
      s1_mode_q  <= 2'd0;
      s1_bits_q  <= 8'd0;
      ready_q    <= 1'b0;
      pixel_q    <= {PW{1'b0}};
      addr_q     <= {ADDR_W{1'b0}};
    end else begin
      s1_valid_q <= accept_s;
      if (accept_s) begin
        s1_pix_q  <= pix_s;
        s1_addr_q <= pcnt_q[ADDR_W-1:0];
        s1_mode_q <= mode_sh_q;
        s1_bits_q <= (mode_sh_q == 2'd3) ? key_sh_q[7:0] : lfsr_q[7:0];
      end
      ready_q <= s1_valid_q;
      if (s1_valid_q) begin
        pixel_q <= apply_wm(s1_pix_q, s1_mode_q, s1_bits_q);
        addr_q  <= s1_addr_q;
      end
    end
  end

  assign cam.wked_pixel       = pixel_q;
  assign cam.wked_pixel_ready = ready_q;
  assign cam.wked_pixel_adrr  = addr_q;
  assign cam.frame_cnt        = frame_cnt_q;
  assign cam.frame_overrun    = overrun_q;

endmodule
